// File: rtl/mdc_pkg.sv
// Shared types and width helpers for the streaming GCD engine.
package mdc_pkg;

   typedef enum logic [1:0] {IDLE, REDUCE, HOLD} mdc_state_t;

   // The iteration counter must hold up to 2*width non-exit REDUCE cycles.
   function automatic int cnt_width(input int width);
      return $clog2(2 * width + 2);
   endfunction

   // The common power-of-two exponent k never exceeds width-1.
   function automatic int shift_width(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/mdc_stream_if.sv
// Operand/result handshake bundle between the operand source, the GCD engine
// and the result consumer.
interface mdc_stream_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = mdc_pkg::cnt_width(WIDTH)
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] dtx_in;
   logic [WIDTH-1:0] dty_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] dt_o;
   logic [CNT_W-1:0] cycles_o;

   modport master (
      output in_valid, dtx_in, dty_in, out_ready,
      input  in_ready, out_valid, dt_o, cycles_o
   );

   modport slave (
      input  in_valid, dtx_in, dty_in, out_ready,
      output in_ready, out_valid, dt_o, cycles_o
   );

endinterface

// File: rtl/mdc_step.sv
// One binary (Stein) reduction step: decides whether the pair is finished and,
// if not, how x, y and the shared power-of-two exponent advance.
module mdc_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] x_nxt,
   output logic [WIDTH-1:0] y_nxt,
   output logic             k_inc,
   output logic             done,
   output logic             sel_result
);

   // Priority list: exit cases first, then halving of even operands, and
   // finally the odd/odd subtract-and-halve (the compare keeps it underflow free).
   always_comb begin
      x_nxt      = x;
      y_nxt      = y;
      k_inc      = 1'b0;
      done       = 1'b0;
      sel_result = 1'b0;
      if (x == '0) begin
         done       = 1'b1;
         sel_result = 1'b1;
      end else if (y == '0) begin
         done = 1'b1;
      end else if (x == y) begin
         done = 1'b1;
      end else if (!x[0] && !y[0]) begin
         x_nxt = x >> 1;
         y_nxt = y >> 1;
         k_inc = 1'b1;
      end else if (!x[0]) begin
         x_nxt = x >> 1;
      end else if (!y[0]) begin
         y_nxt = y >> 1;
      end else if (x > y) begin
         x_nxt = (x - y) >> 1;
      end else begin
         y_nxt = (y - x) >> 1;
      end
   end

endmodule

// File: rtl/mdc_stream.sv
// Streaming GCD engine: accepts an operand pair, reduces it with Stein's
// algorithm one step per enabled cycle, then holds the result and iteration
// count until the consumer takes it. enb low freezes everything.
module mdc_stream
   import mdc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = cnt_width(WIDTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enb,
   mdc_stream_if.slave bus
);

   localparam int KW = shift_width(WIDTH);

   mdc_state_t       state, state_nxt;
   logic [WIDTH-1:0] x, y, x_step, y_step, dt_r;
   logic [KW-1:0]    k;
   logic [CNT_W-1:0] count, cycles_r;
   logic             k_inc, step_done, sel_result;
   logic             load, advance, finish;

   mdc_step #(.WIDTH(WIDTH)) u_step (
      .x          (x),
      .y          (y),
      .x_nxt      (x_step),
      .y_nxt      (y_step),
      .k_inc      (k_inc),
      .done       (step_done),
      .sel_result (sel_result)
   );

   // Handshake outputs follow the state directly so a reset drops out_valid at once.
   assign bus.in_ready  = (state == IDLE) && !rst;
   assign bus.out_valid = (state == HOLD);
   assign bus.dt_o      = dt_r;
   assign bus.cycles_o  = cycles_r;

   // State register; only moves on enabled edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else if (enb) begin
         state <= state_nxt;
      end
   end

   // Next-state logic plus the datapath strobes for load, step and exit.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      advance   = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               load      = 1'b1;
               state_nxt = REDUCE;
            end
         end
         REDUCE: begin
            if (step_done) begin
               finish    = 1'b1;
               state_nxt = HOLD;
            end else begin
               advance = 1'b1;
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Working operands, exponent, counter and the held result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x        <= '0;
         y        <= '0;
         k        <= '0;
         count    <= '0;
         dt_r     <= '0;
         cycles_r <= '0;
      end else if (enb) begin
         if (load) begin
            x     <= bus.dtx_in;
            y     <= bus.dty_in;
            k     <= '0;
            count <= '0;
         end else if (advance) begin
            x     <= x_step;
            y     <= y_step;
            count <= count + 1'b1;
            if (k_inc) begin
               k <= k + 1'b1;
            end
         end else if (finish) begin
            dt_r     <= (sel_result ? y : x) << k;
            cycles_r <= count;
         end
      end
   end

endmodule

// File: tb/tb_mdc_stream.sv
// Directed and random checks of the streaming GCD engine at WIDTH=8 and 16.
module tb_mdc_stream;

   logic clk = 1'b0;
   logic rst;
   logic enb;

   always #5 clk = ~clk;

   mdc_stream_if #(.WIDTH(8))  if8 ();
   mdc_stream_if #(.WIDTH(16)) if16 ();

   mdc_stream #(.WIDTH(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .enb (enb),
      .bus (if8.slave)
   );

   mdc_stream #(.WIDTH(16)) dut16 (
      .clk (clk),
      .rst (rst),
      .enb (enb),
      .bus (if16.slave)
   );

   typedef struct {
      logic [31:0] g;
      logic [31:0] c;
   } exp_t;

   exp_t q8[$];
   exp_t q16[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_cyc = 0;

   // Free-running edge counter used for latency measurement.
   always @(posedge clk) cyc <= cyc + 1;

   // Euclid's algorithm: an independent reference for the GCD value.
   function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Counts the non-exit reduction steps the binary algorithm takes.
   function automatic logic [31:0] stein_cycles(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] n = 0;
      while (!(a == 0 || b == 0 || a == b)) begin
         if (!a[0] && !b[0]) begin
            a = a >> 1;
            b = b >> 1;
         end else if (!a[0]) a = a >> 1;
         else if (!b[0]) b = b >> 1;
         else if (a > b) a = (a - b) >> 1;
         else b = (b - a) >> 1;
         n++;
      end
      return n;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive a pair, push its expected result, and wait (bounded) until accepted.
   task automatic applyStimulus(input bit w16, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   n = 0;
      bit   rdy;
      e.g = gcd_ref(a, b);
      e.c = stein_cycles(a, b);
      if (w16) begin
         if16.dtx_in = a[15:0]; if16.dty_in = b[15:0]; if16.in_valid = 1'b1;
         q16.push_back(e);
      end else begin
         if8.dtx_in = a[7:0]; if8.dty_in = b[7:0]; if8.in_valid = 1'b1;
         q8.push_back(e);
      end
      rdy = w16 ? if16.in_ready : if8.in_ready;
      while (!rdy && n < 50) begin
         step();
         n++;
         rdy = w16 ? if16.in_ready : if8.in_ready;
      end
      chk("accept_timeout", 32'(n < 50), 1);
      step();
      acc_cyc = cyc;
      if (w16) if16.in_valid = 1'b0;
      else     if8.in_valid  = 1'b0;
   endtask

   // Wait (bounded) for a result, compare it with the scoreboard head, optionally
   // hold it under back-pressure, then hand it off.
   task automatic checkOutput(input bit w16, input string tag, input int hold, input bit lat);
      exp_t        e;
      int          n = 0;
      bit          v;
      logic [31:0] obs_d, obs_c;
      v = w16 ? if16.out_valid : if8.out_valid;
      while (!v && n < 200) begin
         step();
         n++;
         v = w16 ? if16.out_valid : if8.out_valid;
      end
      chk({tag, "_valid"}, 32'(v), 1);
      e.g = 32'hFFFF_FFFF;
      e.c = 32'hFFFF_FFFF;
      if (w16 && q16.size() > 0) e = q16.pop_front();
      else if (!w16 && q8.size() > 0) e = q8.pop_front();
      obs_d = w16 ? 32'(if16.dt_o) : 32'(if8.dt_o);
      obs_c = w16 ? 32'(if16.cycles_o) : 32'(if8.cycles_o);
      chk({tag, "_dt"}, obs_d, e.g);
      chk({tag, "_cycles"}, obs_c, e.c);
      chk({tag, "_bound"}, 32'(obs_c <= (w16 ? 32 : 16)), 1);
      if (lat) chk({tag, "_latency"}, 32'(cyc - acc_cyc), e.c + 1);
      for (int i = 0; i < hold; i++) begin
         step();
         chk({tag, "_hold_dt"}, w16 ? 32'(if16.dt_o) : 32'(if8.dt_o), e.g);
         chk({tag, "_hold_valid"}, w16 ? 32'(if16.out_valid) : 32'(if8.out_valid), 1);
         chk({tag, "_hold_inrdy"}, w16 ? 32'(if16.in_ready) : 32'(if8.in_ready), 0);
      end
      if (w16) if16.out_ready = 1'b1; else if8.out_ready = 1'b1;
      step();
      if (w16) if16.out_ready = 1'b0; else if8.out_ready = 1'b0;
      chk({tag, "_drop"}, w16 ? 32'(if16.out_valid) : 32'(if8.out_valid), 0);
      chk({tag, "_idle"}, w16 ? 32'(if16.in_ready) : 32'(if8.in_ready), 1);
   endtask

   initial begin
      exp_t e;
      rst = 1'b0;
      enb = 1'b1;
      if8.in_valid = 1'b0;  if8.out_ready = 1'b0;  if8.dtx_in = '0;  if8.dty_in = '0;
      if16.in_valid = 1'b0; if16.out_ready = 1'b0; if16.dtx_in = '0; if16.dty_in = '0;
      #1 rst = 1'b1;
      #11;
      chk("rst_dt", 32'(if8.dt_o), 0);
      chk("rst_cycles", 32'(if8.cycles_o), 0);
      chk("rst_valid", 32'(if8.out_valid), 0);
      chk("rst_valid16", 32'(if16.out_valid), 0);
      rst = 1'b0;
      step();
      chk("rst_inrdy", 32'(if8.in_ready), 1);

      // Basic pair with immediate consumer
      applyStimulus(0, 86, 96);
      checkOutput(0, "basic", 0, 1);

      // Zero and identity operands
      applyStimulus(0, 0, 45);  checkOutput(0, "zero_x", 0, 1);
      applyStimulus(0, 45, 0);  checkOutput(0, "zero_y", 0, 1);
      applyStimulus(0, 0, 0);   checkOutput(0, "zero_xy", 0, 1);
      applyStimulus(0, 77, 77); checkOutput(0, "equal", 0, 1);

      // Back-pressure: result held five cycles
      applyStimulus(0, 48, 18);
      checkOutput(0, "backpr", 5, 1);

      // Stall mid-REDUCE: frozen outputs, same result and count
      applyStimulus(0, 86, 96);
      step();
      step();
      enb = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_valid", 32'(if8.out_valid), 0);
         chk("stall_inrdy", 32'(if8.in_ready), 0);
      end
      enb = 1'b1;
      checkOutput(0, "stall", 0, 0);

      // Reset two cycles into REDUCE: the in-flight result is lost
      applyStimulus(0, 86, 96);
      step();
      step();
      rst = 1'b1;
      #1;
      chk("midrst_valid", 32'(if8.out_valid), 0);
      if (q8.size() > 0) e = q8.pop_front();
      step();
      rst = 1'b0;
      #1;
      chk("midrst_inrdy", 32'(if8.in_ready), 1);
      chk("midrst_valid2", 32'(if8.out_valid), 0);
      applyStimulus(0, 12, 8);
      checkOutput(0, "after_rst", 0, 1);

      // Handshake ordering: next pair presented during HOLD
      applyStimulus(0, 100, 75);
      if8.dtx_in = 8'd63; if8.dty_in = 8'd42; if8.in_valid = 1'b1;
      e.g = gcd_ref(63, 42);
      e.c = stein_cycles(63, 42);
      q8.push_back(e);
      checkOutput(0, "order_a", 2, 1);
      step();
      acc_cyc = cyc;
      chk("order_accept", 32'(if8.in_ready), 0);
      if8.in_valid = 1'b0;
      checkOutput(0, "order_b", 0, 1);

      // Wider engine: corner pairs then random sweep
      applyStimulus(1, 65535, 65535); checkOutput(1, "w16_max", 0, 1);
      applyStimulus(1, 32768, 12288); checkOutput(1, "w16_pow2", 0, 1);
      for (int i = 0; i < 1000; i++) begin
         applyStimulus(1, 32'($urandom_range(0, 65535)), 32'($urandom_range(0, 65535)));
         checkOutput(1, "w16_rand", 0, 1);
      end

      chk("sb_empty", 32'(q8.size() + q16.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdc_stream.md
Name: mdc_stream

Overview:
- Parametrised greatest-common-divisor engine; successor to the fixed 8-bit subtractive mdc FSM.
- Uses binary (Stein) reduction, with operand width set by parameter.
- Valid/ready handshakes on input and output; enb acts as a global stall.
- Reports the iteration count with each result.
- Sits between an operand source and a result consumer in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2)
- CNT_W, $clog2(2*WIDTH+2), width of iteration counter output

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- enb  input  1  clock enable; 0 freezes all state and outputs (handshake outputs hold)
- in_valid  input  1  operand pair valid
- in_ready  output  1  engine can accept operands
- dtx_in  input  WIDTH  operand X
- dty_in  input  WIDTH  operand Y
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- dt_o  output  WIDTH  gcd(X,Y)
- cycles_o  output  CNT_W  number of REDUCE cycles spent on this result

Behaviour:
- Reset (async, rst=1): state=IDLE; x, y, k, count, dt_o, cycles_o = 0; out_valid=0. in_ready=1 once rst deasserts.
- All transitions below happen only on clk edges with enb=1. With enb=0, nothing changes.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - REDUCE: in_ready=0, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- IDLE:
  - On in_valid: latch x=dtx_in, y=dty_in, k=0, count=0.
  - Go to REDUCE.
- REDUCE, evaluated in priority order each cycle:
  1. x==0 -> dt_o=y<<k, go to HOLD.
  2. y==0 -> dt_o=x<<k, go to HOLD.
  3. x==y -> dt_o=x<<k, go to HOLD.
  4. Both even -> x>>=1, y>>=1, k++.
  5. Only x even -> x>>=1.
  6. Only y even -> y>>=1.
  7. Both odd -> if x>y then x=(x-y)>>1, else y=(y-x)>>1.
  - count increments on every REDUCE cycle that does not exit.
  - On exit, cycles_o=count.
- Zero inputs:
  - gcd(0,0)=0, gcd(0,Y)=Y, gcd(X,0)=X.
  - Each exits on the first REDUCE cycle with cycles_o=0.
- Width rules:
  - Subtraction is WIDTH-bit unsigned with no underflow, guaranteed by the compare.
  - k never exceeds WIDTH-1.
  - The shift k is exact: the result fits in WIDTH bits.
- Bound: REDUCE runs at most 2*WIDTH cycles before exit. The verifier checks this with an assertion.
- HOLD:
  - dt_o and cycles_o are stable while out_valid=1.
  - On out_ready: out_valid drops next cycle, go to IDLE.
  - No back-to-back bypass: a new operand is accepted at the earliest one cycle after result handoff.
- Latency: 1 cycle accept + (cycles_o+1) REDUCE cycles to out_valid.
- in_valid during REDUCE/HOLD is ignored (in_ready=0). The source must hold operands until accepted.
- Reset mid-operation forces IDLE immediately and drops out_valid asynchronously. The in-flight result is lost.
- dt_o holds its last value in IDLE/REDUCE. It is meaningful only when out_valid=1.

Decomposition:
- mdc_pkg:
  - typedef enum logic [1:0] {IDLE, REDUCE, HOLD} mdc_state_t.
  - Helper function for the counter width.
- Sub-module mdc_step, combinational, parametrised by WIDTH:
  - Inputs: x, y.
  - Outputs: next x, next y, k_inc, done, sel_result.
  - Implements the REDUCE priority list.
- mdc_stream holds the FSM, registers, handshakes and counter.

Test Plan:
- Basic: WIDTH=8, X=86, Y=96, out_ready=1 -> out_valid once, dt_o=2. cycles_o matches a reference model; total latency = cycles_o+2.
- Zero/identity:
  - (0,45) -> 45.
  - (45,0) -> 45.
  - (0,0) -> 0.
  - (77,77) -> 77.
  - Each with cycles_o=0 and out_valid on the 2nd edge after accept.
- Back-pressure and stall:
  - (48,18) with out_ready=0 for 5 cycles -> dt_o=6 held stable, in_ready=0 throughout.
  - Pulsing enb=0 mid-REDUCE -> same result; cycles_o excludes stalled cycles.
- Width sweep: WIDTH=16, (65535,65535)=65535, (32768,12288)=4096 -> cycles_o <= 32; random 1000 pairs vs software gcd.
- Reset mid-op: assert rst 2 cycles into REDUCE of (86,96) -> out_valid=0 and in_ready=1 after release. A new pair (12,8) then returns 4.
- Handshake ordering: hold in_valid high with a new pair during HOLD -> it is accepted only in the cycle after out_ready handoff. No result is dropped or duplicated.
